// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, receive-buffer defaults and the
// per-cycle FIFO operation decode used by uart_rx_buffer.
package uart_pkg;

  localparam int unsigned UART_BYTE_W                = 8;
  localparam int unsigned UART_RX_DEPTH_DEFAULT      = 8;
  localparam int unsigned UART_RX_IRQ_THRESH_DEFAULT = 1;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  // What the FIFO does on a given edge.
  typedef enum logic [2:0] {
    FIFO_OP_NONE     = 3'd0,
    FIFO_OP_PUSH     = 3'd1,
    FIFO_OP_POP      = 3'd2,
    FIFO_OP_PUSH_POP = 3'd3,
    FIFO_OP_DROP     = 3'd4
  } fifo_op_e;

  // pop must already be qualified by non-empty; a push into a full FIFO is
  // only dropped when no pop frees a slot on the same edge.
  function automatic fifo_op_e fifo_op_decode(input logic push,
                                              input logic pop,
                                              input logic full);
    fifo_op_e op;
    op = FIFO_OP_NONE;
    if (push && pop) begin
      op = FIFO_OP_PUSH_POP;
    end else if (push && full) begin
      op = FIFO_OP_DROP;
    end else if (push) begin
      op = FIFO_OP_PUSH;
    end else if (pop) begin
      op = FIFO_OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/uart_pulse_sync.sv
// Two-flop synchronizer plus rising-edge detector. Turns an asynchronous
// level/pulse into a single-cycle strobe in the clk domain.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset, clears all three flops
//   async_in  asynchronous input (e.g. RX_STATUS)
//   pulse_out one-cycle strobe on each synchronized rising edge
module uart_pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronizer chain and edge-history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One strobe per rise, however long the input stays high.
  assign pulse_out = sync2_q & ~prev_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures each byte announced by RX_STATUS into a
// small first-word-fall-through FIFO and flags overrun.
// Optional feature macro: UART_RX_IRQ_EN (enables the irq output; when
// undefined irq is tied low and the threshold compare is not built).
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   RX_STATUS  receiver byte-done pulse (BRclk domain, asynchronous)
//   RX_DATA    receiver byte, stable around RX_STATUS
//   rx_pop     removes the head entry (ignored when empty)
//   ovr_clr    clears the sticky overrun flag
//   rx_valid   FIFO non-empty
//   rx_byte    head entry, 8'h00 when empty
//   rx_count   occupancy 0..DEPTH
//   overrun    sticky dropped-byte flag
//   irq        interrupt request
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = UART_RX_DEPTH_DEFAULT,
  parameter int unsigned IRQ_THRESH = UART_RX_IRQ_THRESH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RX_STATUS,
  input  logic [UART_BYTE_W-1:0] RX_DATA,
  input  logic                   rx_pop,
  input  logic                   ovr_clr,
  output logic                   rx_valid,
  output logic [UART_BYTE_W-1:0] rx_byte,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   overrun,
  output logic                   irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time parameter checks.
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_buffer: DEPTH must be a power of two in 2..64");
  end
  if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_buffer: IRQ_THRESH must be in 1..DEPTH");
  end

  uart_byte_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             wr_en;
  logic             push;
  logic             pop_ok;
  logic             full;
  fifo_op_e         op;

  uart_pulse_sync u_pulse_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (RX_STATUS),
    .pulse_out (push)
  );

  assign full   = (count_q == CNT_W'(DEPTH));
  assign pop_ok = rx_pop & (count_q != '0);
  assign op     = fifo_op_decode(push, pop_ok, full);

  // Next-state for pointers, occupancy and overrun.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;

    unique case (op)
      FIFO_OP_PUSH: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
      FIFO_OP_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
      FIFO_OP_PUSH_POP: begin
        // When full, wr_ptr equals rd_ptr: the head slot is recycled for the
        // new byte on the same edge it is consumed.
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      FIFO_OP_DROP: begin
        overrun_d = 1'b1;
      end
      default: begin
      end
    endcase

    // A drop on the same edge as a clear keeps the flag set.
    if (ovr_clr && op != FIFO_OP_DROP) begin
      overrun_d = 1'b0;
    end

    valid_d = (count_d != '0);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset; contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= RX_DATA;
    end
  end

  assign rx_valid = valid_q;
  assign rx_byte  = valid_q ? mem_q[rd_ptr_q] : '0;
  assign rx_count = count_q;
  assign overrun  = overrun_q;

`ifdef UART_RX_IRQ_EN
  assign irq = (count_q >= CNT_W'(IRQ_THRESH)) | overrun_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer (DEPTH=8, IRQ_THRESH=4).
// A queue-based model predicts occupancy/head/overrun; every cycle the
// outputs are compared to it, and literal expectations pin key points.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned IRQ_THRESH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_status = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_pop = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [3:0] rx_count;
  logic       overrun;
  logic       irq;

  int tests = 0;
  int fails = 0;

  // Model state: owned by the model process except push_at/push_byte,
  // which only the stimulus writes.
  byte unsigned model_q[$];
  bit           model_ovr = 1'b0;
  int           cyc = 0;
  int           push_at = -1;
  byte unsigned push_byte = 8'h00;

  uart_rx_buffer #(
    .DEPTH      (DEPTH),
    .IRQ_THRESH (IRQ_THRESH)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .RX_STATUS (rx_status),
    .RX_DATA   (rx_data),
    .rx_pop    (rx_pop),
    .ovr_clr   (ovr_clr),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: a byte lands on the 3rd edge after RX_STATUS rises.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      model_ovr = 1'b0;
    end else begin
      bit do_pop;
      bit dropped;
      int sz0;
      cyc     = cyc + 1;
      sz0     = model_q.size();
      do_pop  = rx_pop && (sz0 > 0);
      dropped = 1'b0;
      if (do_pop) void'(model_q.pop_front());
      if (cyc == push_at) begin
        if (sz0 == DEPTH && !do_pop) dropped = 1'b1;
        else model_q.push_back(push_byte);
      end
      if (dropped) model_ovr = 1'b1;
      else if (ovr_clr) model_ovr = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [7:0] e_byte;
    logic       e_irq;
    e_byte = (model_q.size() > 0) ? model_q[0] : 8'h00;
`ifdef UART_RX_IRQ_EN
    e_irq = (model_q.size() >= IRQ_THRESH) || model_ovr;
`else
    e_irq = 1'b0;
`endif
    check("cyc_rx_valid", 32'(rx_valid), 32'(model_q.size() > 0));
    check("cyc_rx_byte",  32'(rx_byte),  32'(e_byte));
    check("cyc_rx_count", 32'(rx_count), 32'(model_q.size()));
    check("cyc_overrun",  32'(overrun),  32'(model_ovr));
    check("cyc_irq",      32'(irq),      32'(e_irq));
  endtask

  // Advance one clock: compare on the falling edge, return just after rise.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  // Byte pulse; pop/clr optionally aligned with the edge that writes it.
  task automatic send(input logic [7:0] b, input logic pop_at_push, input logic clr_at_push);
    rx_data   = b;
    rx_status = 1'b1;
    push_byte = b;
    push_at   = cyc + 3;
    tick();
    tick();
    rx_pop  = pop_at_push;
    ovr_clr = clr_at_push;
    tick();
    rx_pop    = 1'b0;
    ovr_clr   = 1'b0;
    rx_status = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, 32'(rx_byte), 32'(exp));
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_byte",  32'(rx_byte),  32'h00);
    check("reset_count", 32'(rx_count), 32'd0);
    check("reset_ovr",   32'(overrun),  32'd0);
    check("reset_irq",   32'(irq),      32'd0);

    // Single byte with latency observation.
    rx_data   = 8'hA5;
    rx_status = 1'b1;
    push_byte = 8'hA5;
    push_at   = cyc + 3;
    tick();
    tick();
    check("a5_not_yet", 32'(rx_valid), 32'd0);
    tick();
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_byte",  32'(rx_byte),  32'hA5);
    check("a5_count", 32'(rx_count), 32'd1);
    rx_status = 1'b0;
    tick();
    tick();
    tick();
    check("a5_one_push", 32'(rx_count), 32'd1);
    pop_expect("a5_pop", 8'hA5);
    check("a5_empty_valid", 32'(rx_valid), 32'd0);
    check("a5_empty_byte",  32'(rx_byte),  32'h00);

    // Pop while empty is ignored.
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    check("empty_pop_count", 32'(rx_count), 32'd0);

    // Fill and overflow.
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0);
    check("fill_count", 32'(rx_count), 32'd8);
    check("fill_ovr",   32'(overrun),  32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Clear racing a drop: set wins; a lone clear then works.
    send(8'h0A, 1'b0, 1'b1);
    check("race_ovr_set", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("race_ovr_clr", 32'(overrun), 32'd0);
    for (int i = 1; i <= 8; i++) pop_expect("fill_order", 8'(i));
    check("fill_drained", 32'(rx_count), 32'd0);

    // Full plus simultaneous push and pop.
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
    send(8'h18, 1'b1, 1'b0);
    check("full_pp_count", 32'(rx_count), 32'd8);
    check("full_pp_ovr",   32'(overrun),  32'd0);
    for (int i = 1; i <= 8; i++) pop_expect("full_pp_order", 8'(8'h10 + i));

    // Pointer wrap.
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h40 + i), 1'b0, 1'b0);
      pop_expect("wrap_data", 8'(8'h40 + i));
    end
    check("wrap_count", 32'(rx_count), 32'd0);

    // Reset mid-stream, with irq threshold crossing.
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h80 + i), 1'b0, 1'b0);
`ifdef UART_RX_IRQ_EN
      check("irq_thresh", 32'(irq), 32'(i >= 3));
`else
      check("irq_off", 32'(irq), 32'd0);
`endif
    end
    check("mid_count", 32'(rx_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_byte",  32'(rx_byte),  32'h00);
    check("mid_rst_count", 32'(rx_count), 32'd0);
    check("mid_rst_ovr",   32'(overrun),  32'd0);
    check("mid_rst_irq",   32'(irq),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_count", 32'(rx_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
